// File: rtl/multiword_adder_ctrl.sv
// Multi-word adder: one shared 32-bit adder stepped over WORDS cycles, LS word first.
// Optional macro SUB_MODE_EN enables A-B via the Sub input (B inverted, carry-in forced to 1).
module multiword_adder_ctrl #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [32*WORDS-1:0]   A,
    input  logic [32*WORDS-1:0]   B,
    input  logic                  Cin,
    input  logic                  Sub,
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   Sum,
    output logic                  Cout
);

    localparam int unsigned W  = 32 * WORDS;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry;
    logic [IW-1:0]   idx;

    logic [W-1:0]    b_eff;
    logic            cin_eff;
    logic [31:0]     op_a;
    logic [31:0]     op_b;
    logic            op_c;
    logic [32:0]     add;

    // Operand conditioning applied when an operation is accepted
`ifdef SUB_MODE_EN
    always_comb begin
        b_eff   = Sub ? ~B : B;
        cin_eff = Sub ? 1'b1 : Cin;
    end
`else
    always_comb begin
        b_eff   = B;
        cin_eff = Cin | (Sub & 1'b0);
    end
`endif

    // A back-to-back start in DONE computes word 0 straight from the inputs
    always_comb begin
        op_a = a_q[31:0];
        op_b = b_q[31:0];
        op_c = carry;
        if (state == DONE) begin
            op_a = A[31:0];
            op_b = b_eff[31:0];
            op_c = cin_eff;
        end
        add = 33'(op_a) + 33'(op_b) + 33'(op_c);
    end

    assign busy = (state == ADD) || ((state == DONE) && start);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= b_eff;
                        carry <= cin_eff;
                        Sum   <= '0;
                        Cout  <= 1'b0;
                        idx   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    Sum[32*idx +: 32] <= add[31:0];
                    carry             <= add[32];
                    a_q               <= a_q >> 32;
                    b_q               <= b_q >> 32;
                    if (idx == IW'(WORDS - 1)) begin
                        Cout  <= add[32];
                        done  <= 1'b1;
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        a_q   <= A >> 32;
                        b_q   <= b_eff >> 32;
                        Sum   <= {{(W-32){1'b0}}, add[31:0]};
                        Cout  <= 1'b0;
                        carry <= add[32];
                        idx   <= IW'(1);
                        state <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Directed bench for multiword_adder_ctrl with WORDS=4; honours SUB_MODE_EN if defined.
module tb_multiword_adder_ctrl;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 32 * WORDS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          Cin;
    logic          Sub;
    logic          busy;
    logic          done;
    logic [W-1:0]  Sum;
    logic          Cout;

    int n_checks = 0;
    int n_fail   = 0;

    multiword_adder_ctrl #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Sub   (Sub),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycles from the accepting edge until done is seen (cycle 1 = after that edge)
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) break;
        end
        if (!done) cyc = -1;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, output int cyc);
        A = a; B = b; Cin = c; Sub = s; start = 1'b1;
        wait_done(cyc);
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    int            cyc;
    int            cnt;
    logic [W-1:0]  ones;
    logic [W-1:0]  exp_sub;
    logic          exp_sub_c;

    initial begin
        ones = '1;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_sum",  Sum,      W'(0));
        check("rst_cout", W'(Cout), W'(0));
        rst = 1'b0;
        @(negedge clk);

        // 1 + 1
        do_op(W'(1), W'(1), 1'b0, 1'b0, cyc);
        check("lat_1p1",  W'(cyc),  W'(5));
        check("sum_1p1",  Sum,      W'(2));
        check("cout_1p1", W'(Cout), W'(0));
        check("busy_done_idle", W'(busy), W'(0));

        // Sum holds after done, done is a single pulse
        count_dones(3, cnt);
        check("hold_sum",   Sum,     W'(2));
        check("hold_dones", W'(cnt), W'(0));

        // full ripple: all ones + 0 + Cin
        do_op(ones, W'(0), 1'b1, 1'b0, cyc);
        check("lat_ripple",  W'(cyc),  W'(5));
        check("sum_ripple",  Sum,      W'(0));
        check("cout_ripple", W'(Cout), W'(1));

        // word 0 -> word 1 carry
        do_op(W'(32'hFFFF_FFFF), W'(1), 1'b0, 1'b0, cyc);
        check("sum_w0c",  Sum,      {96'h1, 32'h0});
        check("cout_w0c", W'(Cout), W'(0));

        // subtract request
`ifdef SUB_MODE_EN
        exp_sub = ones - W'(1); exp_sub_c = 1'b0;
`else
        exp_sub = W'(12); exp_sub_c = 1'b0;
`endif
        do_op(W'(5), W'(7), 1'b0, 1'b1, cyc);
        check("sum_sub",  Sum,      exp_sub);
        check("cout_sub", W'(Cout), W'(exp_sub_c));
        Sub = 1'b0;
        @(negedge clk);

        // start and operand changes during ADD are ignored
        A = {32'h1, 32'h2, 32'h3, 32'h4}; B = {32'h10, 32'h20, 32'h30, 32'h40};
        Cin = 1'b0; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        check("busy_add", W'(busy), W'(1));
        @(posedge clk); @(negedge clk);
        start = 1'b1; A = ones; B = ones; Cin = 1'b1;
        wait_done(cyc);
        check("lat_ign",  W'(cyc + 2), W'(5));
        check("sum_ign",  Sum, {32'h11, 32'h22, 32'h33, 32'h44});
        check("cout_ign", W'(Cout), W'(0));
        count_dones(8, cnt);
        check("ign_dones", W'(cnt), W'(0));

        // back-to-back: start on the done cycle
        do_op(W'(100), W'(23), 1'b0, 1'b0, cyc);
        check("sum_b2b1", Sum, W'(123));
        A = {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF}; B = {32'h8000_0000, 32'h0, 32'h0, 32'h1};
        Cin = 1'b1; start = 1'b1;
        #1;
        check("busy_b2b", W'(busy), W'(1));
        wait_done(cyc);
        check("lat_b2b",  W'(cyc), W'(4));
        check("sum_b2b2", Sum, {32'h8000_0000, 32'h0, 32'h1, 32'h1});
        check("cout_b2b", W'(Cout), W'(0));

        // reset in ADD cycle 2 aborts with no done
        @(negedge clk);
        A = ones; B = W'(1); Cin = 1'b0; start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("abort_busy", W'(busy), W'(0));
        check("abort_sum",  Sum,      W'(0));
        check("abort_cout", W'(Cout), W'(0));
        count_dones(8, cnt);
        check("abort_dones", W'(cnt), W'(0));

        // start together with reset is ignored
        rst = 1'b1; start = 1'b1; A = W'(1); B = W'(1);
        @(posedge clk); @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rststart_busy", W'(busy), W'(0));
        count_dones(8, cnt);
        check("rststart_dones", W'(cnt), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
